alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit combinational ALU between two requesters, e.g. the execute stage and the address/branch unit. It accepts one operation per cycle using valid/ready handshakes and drives the ALU's SrcA, SrcB and ALUControl inputs. It captures ALUResult into a one-entry response register, which is returned to the owning requester with its own valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 87 ++++++++
 tb/tb_alu_share_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit combinational ALU between two requesters,
// with a one-entry response register returned over a per-requester valid/ready handshake.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_ctrl_0,
    input  logic [2:0]  req_ctrl_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUResult,
    output logic        busy
);

    logic        last;
    logic        rvalid;
    logic        rowner;
    logic [31:0] rdata;

    logic owner_ready;
    logic can_issue;
    logic grant_0;
    logic grant_1;
    logic accept;

    // The response register may be drained and refilled in the same cycle.
    assign owner_ready = rowner ? rsp_ready_1 : rsp_ready_0;
    assign can_issue   = !rvalid || owner_ready;

    // On contention the requester that was not granted last wins.
    assign grant_0 = req_valid_0 && (!req_valid_1 || last);
    assign grant_1 = req_valid_1 && (!req_valid_0 || !last);

    assign req_ready_0 = can_issue && grant_0;
    assign req_ready_1 = can_issue && grant_1;
    assign accept      = req_ready_0 || req_ready_1;

    always_comb begin
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        ALUControl = 3'd0;
        if (grant_0) begin
            SrcA       = req_a_0;
            SrcB       = req_b_0;
            ALUControl = req_ctrl_0;
        end else if (grant_1) begin
            SrcA       = req_a_1;
            SrcB       = req_b_1;
            ALUControl = req_ctrl_1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last   <= 1'b1;
            rvalid <= 1'b0;
            rowner <= 1'b0;
            rdata  <= 32'd0;
        end else if (accept) begin
            rdata  <= ALUResult;
            rowner <= grant_1;
            rvalid <= 1'b1;
            last   <= grant_1;
        end else if (rvalid && owner_ready) begin
            rvalid <= 1'b0;
        end
    end

    assign rsp_valid_0 = rvalid && !rowner;
    assign rsp_valid_1 = rvalid && rowner;
    assign rsp_result  = rdata;
    assign busy        = rvalid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, a mid-operation reset sequence,
// and random traffic checked against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [2:0]  req_ctrl_0, req_ctrl_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_result;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference ALU; codes outside the supported set return 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b010:  return a + b;
            3'b011:  return a | b;
            3'b110:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign ALUResult = alu_fn(SrcA, SrcB, ALUControl);

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0;
        logic [2:0]  c0;
        logic [31:0] a1, b1;
        logic [2:0]  c1;
        logic        rr0, rr1;
        logic        er0, er1, erv0, erv1;
        logic [31:0] eres;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic v0, input logic v1,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                                input logic rr0, input logic rr1,
                                input logic er0, input logic er1,
                                input logic erv0, input logic erv1, input logic [31:0] eres);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.rr0 = rr0; v.rr1 = rr1;
        v.er0 = er0; v.er1 = er1; v.erv0 = erv0; v.erv1 = erv1;
        v.eres = eres;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid_0 = v.v0; req_valid_1 = v.v1;
        req_a_0 = v.a0; req_b_0 = v.b0; req_ctrl_0 = v.c0;
        req_a_1 = v.a1; req_b_1 = v.b1; req_ctrl_1 = v.c1;
        rsp_ready_0 = v.rr0; rsp_ready_1 = v.rr1;
    endtask

    task automatic idleInputs();
        req_valid_0 = 0; req_valid_1 = 0;
        req_a_0 = 0; req_b_0 = 0; req_ctrl_0 = 0;
        req_a_1 = 0; req_b_1 = 0; req_ctrl_1 = 0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Transaction-level model: pending response (owner, data) and round-robin priority.
    bit          m_pend;
    int          m_owner;
    logic [31:0] m_data;
    int          m_last;

    task automatic modelReset();
        m_pend = 0; m_owner = 0; m_data = 0; m_last = 1;
    endtask

    task automatic randomCycle(input int n);
        bit blocked;
        int g;
        logic [31:0] ea, eb;
        logic [2:0]  ec;
        req_valid_0 = ($urandom_range(0, 9) < 7);
        req_valid_1 = ($urandom_range(0, 9) < 7);
        req_a_0 = $urandom; req_b_0 = $urandom; req_ctrl_0 = 3'($urandom_range(0, 7));
        req_a_1 = $urandom; req_b_1 = $urandom; req_ctrl_1 = 3'($urandom_range(0, 7));
        rsp_ready_0 = ($urandom_range(0, 9) < 6);
        rsp_ready_1 = ($urandom_range(0, 9) < 6);
        #1;
        blocked = m_pend && !(m_owner == 0 ? rsp_ready_0 : rsp_ready_1);
        if (req_valid_0 && req_valid_1) g = (m_last == 0) ? 1 : 0;
        else if (req_valid_0)           g = 0;
        else if (req_valid_1)           g = 1;
        else                            g = -1;
        ea = (g == 0) ? req_a_0 : (g == 1) ? req_a_1 : 32'd0;
        eb = (g == 0) ? req_b_0 : (g == 1) ? req_b_1 : 32'd0;
        ec = (g == 0) ? req_ctrl_0 : (g == 1) ? req_ctrl_1 : 3'd0;
        checkOutput($sformatf("rnd%0d ready0", n), 32'(req_ready_0), 32'(!blocked && g == 0));
        checkOutput($sformatf("rnd%0d ready1", n), 32'(req_ready_1), 32'(!blocked && g == 1));
        checkOutput($sformatf("rnd%0d rsp_valid_0", n), 32'(rsp_valid_0), 32'(m_pend && m_owner == 0));
        checkOutput($sformatf("rnd%0d rsp_valid_1", n), 32'(rsp_valid_1), 32'(m_pend && m_owner == 1));
        checkOutput($sformatf("rnd%0d result", n), rsp_result, m_data);
        checkOutput($sformatf("rnd%0d busy", n), 32'(busy), 32'(m_pend));
        checkOutput($sformatf("rnd%0d SrcA", n), SrcA, ea);
        checkOutput($sformatf("rnd%0d SrcB", n), SrcB, eb);
        checkOutput($sformatf("rnd%0d ALUControl", n), 32'(ALUControl), 32'(ec));
        @(posedge clk);
        if (g >= 0 && !blocked) begin
            m_data  = alu_fn(ea, eb, ec);
            m_owner = g;
            m_pend  = 1;
            m_last  = g;
        end else if (m_pend && !blocked) begin
            m_pend = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        doReset();
        #1;
        checkOutput("reset rsp_valid_0", 32'(rsp_valid_0), 32'd0);
        checkOutput("reset rsp_valid_1", 32'(rsp_valid_1), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset result", rsp_result, 32'd0);
        checkOutput("reset SrcA", SrcA, 32'd0);
        checkOutput("reset ALUControl", 32'(ALUControl), 32'd0);
        @(negedge clk);

        vecs[0]  = mk(1,0, 5,3,3'b010, 0,0,3'b000, 1,1, 1,0,0,0, 32'd0);
        vecs[1]  = mk(0,0, 0,0,3'b000, 0,0,3'b000, 1,1, 0,0,1,0, 32'd8);
        vecs[2]  = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 1,1, 0,1,0,0, 32'd8);
        vecs[3]  = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 1,1, 1,0,0,1, 32'h30);
        vecs[4]  = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 1,1, 0,1,1,0, 32'd6);
        vecs[5]  = mk(1,0, 10,4,3'b110, 0,0,3'b000, 1,0, 0,0,0,1, 32'h30);
        vecs[6]  = mk(1,0, 10,4,3'b110, 0,0,3'b000, 1,0, 0,0,0,1, 32'h30);
        vecs[7]  = mk(1,0, 10,4,3'b110, 0,0,3'b000, 1,0, 0,0,0,1, 32'h30);
        vecs[8]  = mk(1,0, 10,4,3'b110, 0,0,3'b000, 1,1, 1,0,0,1, 32'h30);
        vecs[9]  = mk(1,0, 7,9,3'b111, 0,0,3'b000, 1,1, 1,0,1,0, 32'd6);
        vecs[10] = mk(0,0, 0,0,3'b000, 0,0,3'b000, 0,1, 0,0,1,0, 32'd0);
        vecs[11] = mk(0,0, 0,0,3'b000, 0,0,3'b000, 1,1, 0,0,1,0, 32'd0);
        vecs[12] = mk(1,0, 1,2,3'b010, 0,0,3'b000, 0,1, 1,0,0,0, 32'd0);
        vecs[13] = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 0,1, 0,0,1,0, 32'd3);
        vecs[14] = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 0,1, 0,0,1,0, 32'd3);
        vecs[15] = mk(1,1, 10,4,3'b110, 32'hF0,32'h3C,3'b000, 1,1, 0,1,1,0, 32'd3);
        vecs[16] = mk(0,0, 0,0,3'b000, 0,0,3'b000, 1,1, 0,0,0,1, 32'h30);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d ready0", i), 32'(req_ready_0), 32'(vecs[i].er0));
            checkOutput($sformatf("vec%0d ready1", i), 32'(req_ready_1), 32'(vecs[i].er1));
            checkOutput($sformatf("vec%0d rsp_valid_0", i), 32'(rsp_valid_0), 32'(vecs[i].erv0));
            checkOutput($sformatf("vec%0d rsp_valid_1", i), 32'(rsp_valid_1), 32'(vecs[i].erv1));
            checkOutput($sformatf("vec%0d result", i), rsp_result, vecs[i].eres);
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].erv0 | vecs[i].erv1));
            if (i == 9)
                checkOutput("vec9 ALUControl", 32'(ALUControl), 32'd7);
            @(negedge clk);
        end

        // Reset while a response is pending and both requesters are valid.
        idleInputs();
        req_valid_0 = 1; req_a_0 = 2; req_b_0 = 2; req_ctrl_0 = 3'b010;
        @(negedge clk);
        req_valid_1 = 1; req_a_1 = 1; req_b_1 = 1; req_ctrl_1 = 3'b010;
        #1;
        checkOutput("pre-reset rsp_valid_0", 32'(rsp_valid_0), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset rsp_valid_0", 32'(rsp_valid_0), 32'd0);
        checkOutput("async reset rsp_valid_1", 32'(rsp_valid_1), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset result", rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset ready0", 32'(req_ready_0), 32'd1);
        checkOutput("post-reset ready1", 32'(req_ready_1), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("post-reset first result", rsp_result, 32'd4);
        checkOutput("post-reset first owner", 32'(rsp_valid_0), 32'd1);

        idleInputs();
        doReset();
        modelReset();
        for (int n = 0; n < 400; n++)
            randomCycle(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
